// File: rtl/i2s_capture_writer.sv
// I2S record path: oversamples the codec SClk/LRClk/Din, packs eight 16-bit samples
// per 128-bit word, buffers the words and writes them to sequential SDRAM word addresses.
module i2s_capture_writer #(
    parameter logic [21:0] ADDR_BASE  = 22'h000000,
    parameter logic [21:0] ADDR_LIMIT = 22'h00FFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         Clk50,
    input  logic         reset,
    input  logic         enable,
    input  logic         SClk,
    input  logic         LRClk,
    input  logic         Din,
    input  logic         sdram_Wait,
    input  logic         sdram_ac,
    output logic         sdram_wr,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_wdata,
    output logic         busy,
    output logic         rec_done,
    output logic         overflow,
    output logic [2:0]   fifo_level
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     sclk_sync_r;
    logic [1:0]     lr_sync_r;
    logic [1:0]     din_sync_r;
    logic           sclk_prev_r;
    logic           lr_last_r;
    logic [4:0]     bit_cnt_r;
    logic [15:0]    shift_r;
    logic           armed_r;
    logic [2:0]     pack_idx_r;
    logic [111:0]   pack_r;
    logic [127:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [1:0]     state_r;
    logic           sdram_wr_r;
    logic           busy_r;
    logic [21:0]    sdram_addr_r;
    logic           rec_done_r;
    logic           overflow_r;

    logic           sclk_rise_s;
    logic           lr_s;
    logic           din_s;
    logic           lr_change_s;
    logic           sample_done_s;
    logic [15:0]    sample_s;
    logic           accept_s;
    logic           word_done_s;
    logic           full_s;
    logic           push_s;
    logic           drop_s;
    logic           pop_s;
    logic           clear_s;
    logic [127:0]   full_word_s;

    assign sclk_rise_s   = sclk_sync_r[1] & ~sclk_prev_r;
    assign lr_s          = lr_sync_r[1];
    assign din_s         = din_sync_r[1];
    assign lr_change_s   = sclk_rise_s & (lr_s != lr_last_r);
    assign sample_done_s = sclk_rise_s & ~lr_change_s & (bit_cnt_r == 5'd15);
    assign sample_s      = {shift_r[14:0], din_s};
    assign accept_s      = sample_done_s & armed_r & enable & ~rec_done_r;
    assign word_done_s   = accept_s & (pack_idx_r == 3'd7);
    assign full_s        = (count_r == CW'(FIFO_DEPTH));
    assign push_s        = word_done_s & ~full_s;
    assign drop_s        = word_done_s & full_s;
    assign pop_s         = (state_r == ST_DONE);
    assign clear_s       = (state_r == ST_IDLE) & (~enable | rec_done_r);
    assign full_word_s   = {sample_s, pack_r};

    // Two-flop synchronisers for the codec inputs plus SClk edge history
    always_ff @(posedge Clk50) begin
        if (reset) begin
            sclk_sync_r <= 2'b00;
            lr_sync_r   <= 2'b00;
            din_sync_r  <= 2'b00;
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], SClk};
            lr_sync_r   <= {lr_sync_r[0], LRClk};
            din_sync_r  <= {din_sync_r[0], Din};
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    // Slot framing: the rise that shows a new LR carries the delay bit, then 16 data bits
    always_ff @(posedge Clk50) begin
        if (reset) begin
            lr_last_r <= 1'b0;
            bit_cnt_r <= 5'd16;
            shift_r   <= 16'h0000;
            armed_r   <= 1'b0;
        end else begin
            if (lr_change_s) begin
                lr_last_r <= lr_s;
                bit_cnt_r <= 5'd0;
            end else if (sclk_rise_s && (bit_cnt_r != 5'd16)) begin
                shift_r   <= sample_s;
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if (!enable) begin
                armed_r <= 1'b0;
            end else if (lr_change_s && !lr_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Sample packing; the eighth sample goes straight into the FIFO with the other seven
    always_ff @(posedge Clk50) begin
        if (reset || !enable) begin
            pack_idx_r <= 3'd0;
            pack_r     <= 112'd0;
        end else if (accept_s) begin
            if (pack_idx_r == 3'd7) begin
                pack_idx_r <= 3'd0;
            end else begin
                pack_r[{pack_idx_r, 4'b0000} +: 16] <= sample_s;
                pack_idx_r <= pack_idx_r + 3'd1;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge Clk50) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= full_word_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk50) begin
        if (reset || clear_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // SDRAM writer: Idle -> Req (hold until ack) -> Done (pop, advance) -> Idle
    always_ff @(posedge Clk50) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sdram_wr_r   <= 1'b0;
            busy_r       <= 1'b0;
            sdram_addr_r <= ADDR_BASE;
            rec_done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!enable) begin
                        sdram_addr_r <= ADDR_BASE;
                        rec_done_r   <= 1'b0;
                    end else if ((count_r != '0) && !sdram_Wait && !rec_done_r) begin
                        state_r    <= ST_REQ;
                        sdram_wr_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (sdram_ac) begin
                        state_r    <= ST_DONE;
                        sdram_wr_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (sdram_addr_r == ADDR_LIMIT) begin
                        rec_done_r <= 1'b1;
                    end else begin
                        sdram_addr_r <= sdram_addr_r + 22'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sdram_wr_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow, cleared only by the idle rewind while stopped
    always_ff @(posedge Clk50) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && !enable) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign sdram_wr    = sdram_wr_r;
    assign sdram_addr  = sdram_addr_r;
    assign sdram_wdata = fifo_mem_r[rd_ptr_r];
    assign busy        = busy_r;
    assign rec_done    = rec_done_r;
    assign overflow    = overflow_r;
    assign fifo_level  = 3'(count_r);

endmodule

// File: tb/tb_i2s_capture_writer.sv
// Bench for i2s_capture_writer: an I2S codec model feeds two instances (default limit and
// a 3-word limit); expected SDRAM writes are queued up front and checked as they are acked.
module tb_i2s_capture_writer;

    localparam logic [21:0] BASE_M = 22'h000010;

    logic         Clk50 = 1'b0;
    logic         reset, enable, SClk, LRClk, Din;
    logic         wait_m, ac_m, wr_m, busy_m, done_m, ovf_m;
    logic [21:0]  addr_m;
    logic [127:0] wdata_m;
    logic [2:0]   lvl_m;
    logic         wait_l, ac_l, wr_l, busy_l, done_l, ovf_l;
    logic [21:0]  addr_l;
    logic [127:0] wdata_l;
    logic [2:0]   lvl_l;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [21:0]  addr;
        logic [127:0] data;
    } exp_t;
    exp_t exp_m[$];
    exp_t exp_l[$];
    exp_t e_m, e_l;
    int   nwr_m = 0, nwr_l = 0, cnt_m = 0, cnt_l = 0;
    bit   ack_en_m = 1'b1, ack_en_l = 1'b1;

    int   codec_frame = 0;
    logic codec_slot = 1'b1;
    int   codec_bit = 0;
    bit   codec_run = 1'b0;

    i2s_capture_writer #(.ADDR_BASE(BASE_M), .ADDR_LIMIT(22'h00FFFF), .FIFO_DEPTH(4)) dut (
        .Clk50(Clk50), .reset(reset), .enable(enable), .SClk(SClk), .LRClk(LRClk), .Din(Din),
        .sdram_Wait(wait_m), .sdram_ac(ac_m), .sdram_wr(wr_m), .sdram_addr(addr_m),
        .sdram_wdata(wdata_m), .busy(busy_m), .rec_done(done_m), .overflow(ovf_m),
        .fifo_level(lvl_m));

    i2s_capture_writer #(.ADDR_BASE(22'h000000), .ADDR_LIMIT(22'h000002), .FIFO_DEPTH(4)) dut_lim (
        .Clk50(Clk50), .reset(reset), .enable(enable), .SClk(SClk), .LRClk(LRClk), .Din(Din),
        .sdram_Wait(wait_l), .sdram_ac(ac_l), .sdram_wr(wr_l), .sdram_addr(addr_l),
        .sdram_wdata(wdata_l), .busy(busy_l), .rec_done(done_l), .overflow(ovf_l),
        .fifo_level(lvl_l));

    always #10 Clk50 = ~Clk50;

    function automatic logic [15:0] sa(input int n);
        logic [31:0] v;
        v = 32'h0000A001 + 32'(2 * n);
        return v[15:0];
    endfunction

    function automatic logic [15:0] sb(input int n);
        logic [31:0] v;
        v = 32'h0000B002 + 32'(2 * n);
        return v[15:0];
    endfunction

    // Word holding frames f0..f0+3: left of frame i at [32i+15:32i], right at [32i+31:32i+16]
    function automatic logic [127:0] word_of(input int f0);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) begin
            w[32*i +: 16]      = sa(f0 + i);
            w[32*i + 16 +: 16] = sb(f0 + i);
        end
        return w;
    endfunction

    function automatic logic codec_din(input int fr, input logic sl, input int b);
        logic [15:0] s;
        s = sl ? sb(fr) : sa(fr);
        if (b >= 1 && b <= 16) return s[16 - b];
        else if (b == 0) return 1'b0;
        else return 1'b1;
    endfunction

    // Codec: SClk = Clk50/16, 32-bit slots, LR and data change on SClk fall, MSB one bit late
    initial begin
        SClk = 1'b0; LRClk = 1'b1; Din = 1'b0;
        forever begin
            if (!codec_run) begin
                @(negedge Clk50);
            end else begin
                for (int b = 0; b < 32; b++) begin
                    codec_bit = b;
                    SClk = 1'b0;
                    if (b == 0) LRClk = codec_slot;
                    Din = codec_din(codec_frame, codec_slot, b);
                    repeat (8) @(negedge Clk50);
                    SClk = 1'b1;
                    repeat (8) @(negedge Clk50);
                end
                if (codec_slot) begin
                    codec_slot = 1'b0;
                    codec_frame++;
                end else begin
                    codec_slot = 1'b1;
                end
            end
        end
    end

    // Main-instance SDRAM responder: ack two cycles after sdram_wr, score the write
    always @(negedge Clk50) begin
        if (ack_en_m) begin
            if (ac_m) ac_m = 1'b0;
            else if (wr_m) begin
                if (cnt_m == 1) begin
                    ac_m = 1'b1; cnt_m = 0; nwr_m++; checks++;
                    if (exp_m.size() == 0) begin
                        failures++;
                        $display("FAIL main_unexpected_write addr=%h data=%h", addr_m, wdata_m);
                    end else begin
                        e_m = exp_m.pop_front();
                        if (addr_m !== e_m.addr || wdata_m !== e_m.data) begin
                            failures++;
                            $display("FAIL main_write got addr=%h data=%h want addr=%h data=%h",
                                     addr_m, wdata_m, e_m.addr, e_m.data);
                        end
                    end
                end else cnt_m++;
            end else cnt_m = 0;
        end
    end

    // Limit-instance SDRAM responder
    always @(negedge Clk50) begin
        if (ack_en_l) begin
            if (ac_l) ac_l = 1'b0;
            else if (wr_l) begin
                if (cnt_l == 1) begin
                    ac_l = 1'b1; cnt_l = 0; nwr_l++; checks++;
                    if (exp_l.size() == 0) begin
                        failures++;
                        $display("FAIL lim_unexpected_write addr=%h data=%h", addr_l, wdata_l);
                    end else begin
                        e_l = exp_l.pop_front();
                        if (addr_l !== e_l.addr || wdata_l !== e_l.data) begin
                            failures++;
                            $display("FAIL lim_write got addr=%h data=%h want addr=%h data=%h",
                                     addr_l, wdata_l, e_l.addr, e_l.data);
                        end
                    end
                end else cnt_l++;
            end else cnt_l = 0;
        end
    end

    task automatic push_m(input logic [21:0] a, input logic [127:0] d);
        exp_t e;
        e.addr = a; e.data = d;
        exp_m.push_back(e);
    endtask

    task automatic push_l(input logic [21:0] a, input logic [127:0] d);
        exp_t e;
        e.addr = a; e.data = d;
        exp_l.push_back(e);
    endtask

    task automatic wait_pos(input logic sl, input int bt, output int fr, output bit ok);
        ok = 1'b0; fr = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk50);
            if (codec_run && codec_slot == sl && codec_bit == bt) begin
                ok = 1'b1; fr = codec_frame; break;
            end
        end
    endtask

    task automatic wait_frame(input int fr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge Clk50);
            if (codec_frame == fr && codec_slot == 1'b0 && codec_bit == 8) begin
                ok = 1'b1; break;
            end
        end
    endtask

    task automatic wait_writes(input bit lim, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk50);
            if ((lim ? nwr_l : nwr_m) >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_wr_high(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk50);
            if (wr_m) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; wait_m = 1'b0; wait_l = 1'b1; ac_m = 1'b0; ac_l = 1'b0;
        repeat (3) @(negedge Clk50);
        reset = 1'b0;
        @(negedge Clk50);
        checks++; if (wr_m !== 1'b0)     begin failures++; $display("FAIL reset_wr got=%b want=0", wr_m); end
        checks++; if (busy_m !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b want=0", busy_m); end
        checks++; if (done_m !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b want=0", done_m); end
        checks++; if (ovf_m !== 1'b0)    begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf_m); end
        checks++; if (lvl_m !== 3'd0)    begin failures++; $display("FAIL reset_level got=%0d want=0", lvl_m); end
        checks++; if (addr_m !== BASE_M) begin failures++; $display("FAIL reset_addr got=%h want=%h", addr_m, BASE_M); end
        checks++; if (addr_l !== 22'd0)  begin failures++; $display("FAIL reset_addr_lim got=%h want=0", addr_l); end
    endtask

    task automatic test_basic();
        bit ok;
        int n0;
        n0 = nwr_m;
        enable = 1'b1;
        push_m(BASE_M, word_of(0));
        push_m(BASE_M + 22'd1, word_of(4));
        codec_frame = -1; codec_slot = 1'b1; codec_run = 1'b1;
        wait_writes(1'b0, n0 + 2, 12000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_writes got=%0d want=%0d", nwr_m - n0, 2); end
        repeat (4) @(negedge Clk50);
        checks++; if (addr_m !== BASE_M + 22'd2) begin failures++; $display("FAIL basic_addr_adv got=%h want=%h", addr_m, BASE_M + 22'd2); end
        enable = 1'b0;
        repeat (4) @(negedge Clk50);
        checks++; if (addr_m !== BASE_M) begin failures++; $display("FAIL basic_rewind got=%h want=%h", addr_m, BASE_M); end
    endtask

    task automatic test_arming();
        bit ok;
        int f, n0;
        n0 = nwr_m;
        wait_pos(1'b1, 8, f, ok);
        push_m(BASE_M, word_of(f + 1));
        enable = 1'b1;
        wait_writes(1'b0, n0 + 1, 6000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL arming_write got=%0d want=1", nwr_m - n0); end
        enable = 1'b0;
        repeat (4) @(negedge Clk50);
    endtask

    task automatic test_overflow();
        bit ok;
        int f, n0;
        n0 = nwr_m;
        wait_m = 1'b1;
        wait_pos(1'b0, 8, f, ok);
        enable = 1'b1;
        wait_frame(f + 21, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_codec_wait got=0 want=1"); end
        codec_run = 1'b0;
        @(negedge Clk50);
        checks++; if (lvl_m !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", lvl_m); end
        checks++; if (ovf_m !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", ovf_m); end
        for (int w = 0; w < 4; w++) push_m(BASE_M + 22'(w), word_of(f + 1 + 4 * w));
        wait_m = 1'b0;
        wait_writes(1'b0, n0 + 4, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_drain got=%0d want=4", nwr_m - n0); end
        repeat (100) @(negedge Clk50);
        checks++; if (nwr_m - n0 != 4) begin failures++; $display("FAIL ovf_write_count got=%0d want=4", nwr_m - n0); end
        checks++; if (lvl_m !== 3'd0) begin failures++; $display("FAIL ovf_level_after got=%0d want=0", lvl_m); end
        checks++; if (ovf_m !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", ovf_m); end
        enable = 1'b0;
        repeat (4) @(negedge Clk50);
        checks++; if (ovf_m !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", ovf_m); end
    endtask

    task automatic test_limit();
        bit ok, saw_wr;
        int f, n0;
        n0 = nwr_l;
        wait_m = 1'b1; wait_l = 1'b0; codec_run = 1'b1;
        wait_pos(1'b0, 8, f, ok);
        push_l(22'd0, word_of(f + 1));
        push_l(22'd1, word_of(f + 5));
        push_l(22'd2, word_of(f + 9));
        enable = 1'b1;
        wait_writes(1'b1, n0 + 3, 16000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL limit_writes got=%0d want=3", nwr_l - n0); end
        repeat (4) @(negedge Clk50);
        checks++; if (done_l !== 1'b1)  begin failures++; $display("FAIL limit_done got=%b want=1", done_l); end
        checks++; if (addr_l !== 22'd2) begin failures++; $display("FAIL limit_addr_hold got=%h want=2", addr_l); end
        saw_wr = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge Clk50);
            if (wr_l) saw_wr = 1'b1;
        end
        checks++; if (saw_wr !== 1'b0) begin failures++; $display("FAIL limit_no_rewrite got=1 want=0"); end
        checks++; if (lvl_l !== 3'd0)  begin failures++; $display("FAIL limit_level got=%0d want=0", lvl_l); end
        enable = 1'b0; wait_l = 1'b1;
        repeat (4) @(negedge Clk50);
        checks++; if (done_l !== 1'b0)  begin failures++; $display("FAIL limit_done_clear got=%b want=0", done_l); end
        checks++; if (addr_l !== 22'd0) begin failures++; $display("FAIL limit_rewind got=%h want=0", addr_l); end
    endtask

    task automatic test_stop_restart();
        bit ok;
        int f, n0;
        wait_m = 1'b0; ack_en_m = 1'b0;
        wait_pos(1'b0, 8, f, ok);
        enable = 1'b1;
        wait_wr_high(6000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stop_req got=0 want=1"); end
        checks++; if (addr_m !== BASE_M || wdata_m !== word_of(f + 1)) begin
            failures++; $display("FAIL stop_req_word got addr=%h data=%h want addr=%h data=%h",
                                 addr_m, wdata_m, BASE_M, word_of(f + 1));
        end
        enable = 1'b0;
        repeat (3) @(negedge Clk50);
        checks++; if (wr_m !== 1'b1) begin failures++; $display("FAIL stop_inflight got=%b want=1", wr_m); end
        ac_m = 1'b1;
        @(negedge Clk50);
        ac_m = 1'b0;
        repeat (4) @(negedge Clk50);
        checks++; if (wr_m !== 1'b0 || busy_m !== 1'b0) begin failures++; $display("FAIL stop_idle got wr=%b busy=%b want 0 0", wr_m, busy_m); end
        checks++; if (lvl_m !== 3'd0) begin failures++; $display("FAIL stop_level got=%0d want=0", lvl_m); end
        checks++; if (addr_m !== BASE_M) begin failures++; $display("FAIL stop_addr got=%h want=%h", addr_m, BASE_M); end
        checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL stop_done got=%b want=0", done_m); end
        ack_en_m = 1'b1;
        n0 = nwr_m;
        wait_pos(1'b0, 8, f, ok);
        push_m(BASE_M, word_of(f + 1));
        enable = 1'b1;
        wait_writes(1'b0, n0 + 1, 6000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL restart_write got=%0d want=1", nwr_m - n0); end
        enable = 1'b0;
        repeat (4) @(negedge Clk50);
    endtask

    task automatic test_reset_req();
        bit ok;
        int f;
        ack_en_m = 1'b0;
        wait_pos(1'b0, 8, f, ok);
        enable = 1'b1;
        wait_wr_high(6000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstreq_req got=0 want=1"); end
        @(negedge Clk50);
        reset = 1'b1;
        @(negedge Clk50);
        checks++; if (wr_m !== 1'b0)     begin failures++; $display("FAIL rstreq_wr got=%b want=0", wr_m); end
        checks++; if (busy_m !== 1'b0)   begin failures++; $display("FAIL rstreq_busy got=%b want=0", busy_m); end
        checks++; if (lvl_m !== 3'd0)    begin failures++; $display("FAIL rstreq_level got=%0d want=0", lvl_m); end
        checks++; if (addr_m !== BASE_M) begin failures++; $display("FAIL rstreq_addr got=%h want=%h", addr_m, BASE_M); end
        checks++; if (ovf_m !== 1'b0 || done_m !== 1'b0) begin failures++; $display("FAIL rstreq_flags got ovf=%b done=%b want 0 0", ovf_m, done_m); end
        reset = 1'b0; enable = 1'b0; codec_run = 1'b0;
        repeat (4) @(negedge Clk50);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arming();
        test_overflow();
        test_limit();
        test_stop_restart();
        test_reset_req();
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got main=%0d lim=%0d want 0 0", exp_m.size(), exp_l.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
